clk_divider_multi: RTL and testbench

- Multi-channel, runtime-programmable clock-enable/divided-clock generator; successor to the single fixed-rate divider.
- NCH independent channels share iclk. Each channel has its own terminal count, enable, and mode (50% toggle or 1-cycle pulse).
- Feeds LED blinkers, debouncer sample strobes, display scan and UART-rate enables.
- Channels are reprogrammed from a simple write port and can be phase-aligned with a global sync.

---
 rtl/clk_divider_multi.sv | 80 ++++++++
 tb/tb_clk_divider_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel runs its own counter, terminal count and output mode.
module clk_divider_multi #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 32,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DEFAULT_HZ = 1,
  parameter logic [CNT_W-1:0] DEF_TERM =
    CNT_W'((CLK_FREQ / (2 * DEFAULT_HZ)) - 1),
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             iclk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_term,
  input  logic             wr_mode,
  output logic [NCH-1:0]   oclk,
  output logic [NCH-1:0]   otick
);

  logic [CNT_W-1:0] cnt  [NCH];
  logic [CNT_W-1:0] term [NCH];
  logic [NCH-1:0]   mode;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   wrap;

  // Out-of-range channel numbers match no channel and are dropped.
  always_comb begin
    hit  = '0;
    wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = wr_en && !sync && (wr_ch == CH_W'(i));
      wrap[i] = cnt[i] >= term[i];
    end
  end

  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        term[i]  <= DEF_TERM;
        mode[i]  <= 1'b0;
        oclk[i]  <= 1'b0;
        otick[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync) begin
          cnt[i]   <= '0;
          oclk[i]  <= 1'b0;
          otick[i] <= 1'b0;
        end else if (hit[i]) begin
          term[i]  <= wr_term;
          mode[i]  <= wr_mode;
          cnt[i]   <= '0;
          oclk[i]  <= 1'b0;
          otick[i] <= 1'b0;
        end else if (en[i]) begin
          if (wrap[i]) begin
            cnt[i]   <= '0;
            otick[i] <= 1'b1;
            oclk[i]  <= mode[i] | ~oclk[i];
          end else begin
            cnt[i]   <= cnt[i] + CNT_W'(1);
            otick[i] <= 1'b0;
            oclk[i]  <= oclk[i] & ~mode[i];
          end
        end else begin
          // Paused: toggle level is kept, pulse output drops.
          otick[i] <= 1'b0;
          oclk[i]  <= oclk[i] & ~mode[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: per-cycle scoreboard plus
// directed timing checks on toggle, pulse, hold, sync and reset.
module tb_clk_divider_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;
  localparam int DEFT  = 9;

  logic             iclk    = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH-1:0]   en      = '0;
  logic             sync    = 1'b0;
  logic             wr_en   = 1'b0;
  logic [CH_W-1:0]  wr_ch   = '0;
  logic [CNT_W-1:0] wr_term = '0;
  logic             wr_mode = 1'b0;
  logic [NCH-1:0]   oclk;
  logic [NCH-1:0]   otick;

  clk_divider_multi #(
    .NCH(NCH), .CNT_W(CNT_W),
    .CLK_FREQ(20), .DEFAULT_HZ(1)
  ) dut (
    .iclk(iclk), .reset_n(reset_n),
    .en(en), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_term(wr_term), .wr_mode(wr_mode),
    .oclk(oclk), .otick(otick)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [NCH-1:0] oclk;
    logic [NCH-1:0] otick;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int             m_cnt  [NCH];
  int             m_term [NCH];
  logic [NCH-1:0] m_mode;
  logic [NCH-1:0] m_oclk;
  logic [NCH-1:0] m_otick;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 0;
      m_term[i] = DEFT;
    end
    m_mode  = '0;
    m_oclk  = '0;
    m_otick = '0;
  endtask

  // Next-state of every channel for the inputs now on the pins.
  task automatic m_step();
    for (int i = 0; i < NCH; i++) begin
      if (sync) begin
        m_cnt[i] = 0; m_oclk[i] = 0; m_otick[i] = 0;
      end else if (wr_en && int'(wr_ch) == i) begin
        m_term[i] = int'(wr_term);
        m_mode[i] = wr_mode;
        m_cnt[i] = 0; m_oclk[i] = 0; m_otick[i] = 0;
      end else if (!en[i]) begin
        m_otick[i] = 0;
        if (m_mode[i]) m_oclk[i] = 0;
      end else if (m_cnt[i] >= m_term[i]) begin
        m_cnt[i] = 0;
        m_otick[i] = 1;
        m_oclk[i] = m_mode[i] ? 1'b1 : ~m_oclk[i];
      end else begin
        m_cnt[i]++;
        m_otick[i] = 0;
        if (m_mode[i]) m_oclk[i] = 0;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    m_step();
    sb.push_back('{oclk: m_oclk, otick: m_otick});
    @(posedge iclk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("oclk", 32'(oclk), 32'(e.oclk));
      chk("otick", 32'(otick), 32'(e.otick));
    end
    @(negedge iclk);
  endtask

  task automatic run_until(input int ch, input int maxc,
                           output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!otick[ch] && n < maxc);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int ones;
    int guard;
    logic lvl;

    m_reset();
    repeat (2) @(negedge iclk);
    chk("rst_oclk", 32'(oclk), 32'd0);
    chk("rst_otick", 32'(otick), 32'd0);

    en = 4'hF;
    reset_n = 1'b1;
    run_until(0, 20, n);
    chk("first_tog", n, 10);
    chk("in_phase", 32'(oclk), 32'hF);
    run_until(0, 20, n);
    chk("second_tog", n, 10);
    chk("all_low", 32'(oclk), 32'h0);

    // ch2: pulse every 3 cycles
    wr_en = 1; wr_ch = 2; wr_term = 2; wr_mode = 1;
    tick();
    wr_en = 0;
    run_until(2, 10, n);
    chk("ch2_first", n, 3);
    chk("ch2_pulse", 32'(oclk[2]), 32'd1);
    run_until(2, 10, n);
    chk("ch2_period", n, 3);

    // ch1: term 0 toggle, otick stuck high
    wr_en = 1; wr_ch = 1; wr_term = 0; wr_mode = 0;
    tick();
    wr_en = 0;
    ones = 0;
    repeat (6) begin
      tick();
      if (otick[1]) ones++;
    end
    chk("ch1_ticks", ones, 6);

    // pause ch0 at cnt 4
    guard = 0;
    while (m_cnt[0] != 4 && guard < 40) begin
      tick();
      guard++;
    end
    chk("reach4", 32'(guard < 40), 32'd1);
    lvl = oclk[0];
    en[0] = 1'b0;
    repeat (7) begin
      tick();
      chk("hold_lvl", 32'(oclk[0]), 32'(lvl));
      chk("hold_tick", 32'(otick[0]), 32'd0);
    end
    en[0] = 1'b1;
    run_until(0, 20, n);
    chk("resume", n, 6);

    // sync wins over a same-cycle write to ch3
    repeat (3) tick();
    sync = 1; wr_en = 1; wr_ch = 3;
    wr_term = 1; wr_mode = 1;
    tick();
    sync = 0; wr_en = 0;
    chk("sync_oclk", 32'(oclk), 32'd0);
    run_until(3, 20, n);
    chk("sync_ch3", n, 10);
    chk("align_ch0", 32'(otick[0]), 32'd1);

    // reprogram ch0, then async reset mid-count
    wr_en = 1; wr_ch = 0; wr_term = 4; wr_mode = 1;
    tick();
    wr_en = 0;
    repeat (7) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_oclk", 32'(oclk), 32'd0);
    chk("arst_otick", 32'(otick), 32'd0);
    m_reset();
    @(negedge iclk);
    reset_n = 1'b1;
    run_until(0, 20, n);
    chk("rst_term", n, 10);
    tick();
    chk("rst_mode", 32'(oclk[0]), 32'd1);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
